sevenseg_capture: RTL

//  Receive side of the multiplexed 7-segment display interface: samples segment lines and digit enables.

---
 rtl/sevenseg_capture_if.sv | 26 ++
 rtl/sevenseg_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture_if.sv
// -----------------------------------------------------------------------------
// sevenseg_capture_if
//   Output handshake bundle of the 7-segment capture block.
//   master : drives frame, frame_err, valid, overrun; samples ready
//   slave  : consumer side; samples the frame and drives ready
// Ports / signals
//   frame      4*NUM_DIGITS  decoded frame, digit k at frame[4k+3:4k]
//   frame_err  1             frame contains an undecodable pattern
//   valid      1             frame/frame_err valid, held while !ready
//   ready      1             consumer accepts when valid && ready
//   overrun    1             sticky: a completed frame was dropped
// -----------------------------------------------------------------------------
interface sevenseg_capture_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] frame;
    logic                    frame_err;
    logic                    valid;
    logic                    ready;
    logic                    overrun;

    modport master (output frame, output frame_err, output valid, output overrun,
                    input  ready);
    modport slave  (input  frame, input  frame_err, input  valid, input  overrun,
                    output ready);
endinterface

// File: rtl/sevenseg_capture.sv
// -----------------------------------------------------------------------------
// sevenseg_capture
//   Receive side of a multiplexed 7-segment display. Samples the segment
//   lines and digit enables, filters glitches, decodes each stable pattern to
//   a hex nibble and assembles one nibble per digit into a frame that is
//   offered on a valid/ready handshake.
// Ports
//   Clock     in   single clock, posedge
//   nReset    in   synchronous active-low reset
//   seg       in   [6:0] segments {g,f,e,d,c,b,a}
//   digit_en  in   [NUM_DIGITS-1:0] digit enables (one-hot to capture)
//   out_if    master modport of sevenseg_capture_if (frame/err/valid/ready/overrun)
//   err_count out  [7:0] saturating error counter (only with macro below)
// Optional feature
//   SEVENSEG_CAPTURE_ERRCNT_EN : adds err_count, counting undecodable
//   captures and out-of-order digits.
// -----------------------------------------------------------------------------
module sevenseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3,
    parameter bit SEG_ACT_LOW   = 1'b0
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic [6:0]            seg,
    input  logic [NUM_DIGITS-1:0] digit_en,
    sevenseg_capture_if.master    out_if
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = 4 * NUM_DIGITS;

    typedef enum logic {HUNT, COLLECT} state_t;

    // Returns {undecodable, nibble}; unknown patterns give nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h00;  7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;  7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;  7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;  7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;  7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;  7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;  7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;  7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // ---------------- input stage and stability filter ----------------
    logic [6:0]            seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0] den_q, den_prev_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  same, one_hot, cap_evt;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            seg_q      <= '0;
            den_q      <= '0;
            seg_prev_q <= '0;
            den_prev_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            seg_q      <= SEG_ACT_LOW ? ~seg : seg;
            den_q      <= SEG_ACT_LOW ? ~digit_en : digit_en;
            seg_prev_q <= seg_q;
            den_prev_q <= den_q;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        same    = ({seg_q, den_q} == {seg_prev_q, den_prev_q});
        one_hot = (den_q != '0) && ((den_q & (den_q - 1'b1)) == '0);
        cnt_d   = '0;
        if (same)
            cnt_d = (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
        // The saturating counter already blocks a second event; done_q makes
        // the one-shot explicit until the sample changes.
        cap_evt = same && (cnt_q == CW'(STABLE_CYCLES - 1)) && one_hot && !done_q;
        done_d  = same && (done_q || cap_evt);
    end

    logic [IW-1:0] dig_idx;
    always_comb begin
        dig_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (den_q[k]) dig_idx = IW'(k);
    end

    logic [4:0] dec;
    logic [3:0] nib;
    logic       nib_err;
    assign dec     = decode(seg_q);
    assign nib     = dec[3:0];
    assign nib_err = dec[4];

    // ---------------- frame assembly FSM ----------------
    state_t        state_q, state_d;
    logic [IW-1:0] next_q, next_d;
    logic [FW-1:0] asm_q, asm_d;
    logic          asm_err_q, asm_err_d;
    logic          complete, out_of_order;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= HUNT;
            next_q    <= '0;
            asm_q     <= '0;
            asm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            asm_q     <= asm_d;
            asm_err_q <= asm_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        next_d       = next_q;
        asm_d        = asm_q;
        asm_err_d    = asm_err_q;
        complete     = 1'b0;
        out_of_order = 1'b0;
        if (cap_evt) begin
            if (dig_idx == '0) begin
                // Digit 0 always (re)starts a frame, in either state.
                asm_d[3:0] = nib;
                asm_err_d  = nib_err;
                next_d     = IW'(1);
                if (NUM_DIGITS == 1) begin
                    complete = 1'b1;
                    state_d  = HUNT;
                end else begin
                    state_d  = COLLECT;
                end
            end else if (state_q == COLLECT) begin
                if (dig_idx == next_q) begin
                    asm_d[int'(dig_idx)*4 +: 4] = nib;
                    asm_err_d = asm_err_q | nib_err;
                    next_d    = next_q + IW'(1);
                    if (dig_idx == IW'(NUM_DIGITS - 1)) begin
                        complete = 1'b1;
                        state_d  = HUNT;
                    end
                end else begin
                    out_of_order = 1'b1;
                    state_d      = HUNT;
                end
            end
        end
    end

    // ---------------- output register and handshake ----------------
    logic [FW-1:0] frame_q;
    logic          frame_err_q, valid_q, overrun_q;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            frame_q     <= '0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (complete && (!valid_q || out_if.ready)) begin
            // Slot free or being retired this cycle: load the new frame.
            frame_q     <= asm_d;
            frame_err_q <= asm_err_d;
            valid_q     <= 1'b1;
        end else begin
            if (valid_q && out_if.ready) valid_q <= 1'b0;
            if (complete) overrun_q <= 1'b1;
        end
    end

    assign out_if.frame     = frame_q;
    assign out_if.frame_err = frame_err_q;
    assign out_if.valid     = valid_q;
    assign out_if.overrun   = overrun_q;

`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;
    logic [8:0] errcnt_sum;

    always_comb begin
        errcnt_sum = {1'b0, errcnt_q} + 9'(cap_evt && nib_err) + 9'(out_of_order);
        errcnt_d   = errcnt_sum[8] ? 8'hFF : errcnt_sum[7:0];
    end

    always_ff @(posedge Clock) begin
        if (!nReset) errcnt_q <= '0;
        else         errcnt_q <= errcnt_d;
    end

    assign err_count = errcnt_q;
`endif

endmodule
